// File: rtl/eth_reg_pkg.sv
// Shared types and constants for the KSZ8851 register-bus arbiter.
package eth_reg_pkg;

   localparam int unsigned OFFSET_W = 8;
   localparam int unsigned DATA_W   = 16;

   localparam int unsigned REQ_INIT = 0;
   localparam int unsigned REQ_TX   = 1;
   localparam int unsigned REQ_RX   = 2;

   localparam logic [DATA_W-1:0] RDATA_TIMEOUT = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_HOLD
   } arb_state_e;

   // Command payload presented to the register I/O engine
   typedef struct packed {
      logic [OFFSET_W-1:0] offset;
      logic                length;
      logic                wr;
      logic [DATA_W-1:0]   wdata;
   } reg_cmd_t;

   // Round-robin successor; requester 0 never takes part in the rotation
   function automatic int unsigned rr_after(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? REQ_TX : idx + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first eligible index at or after ptr_i, wrapping.
module rr_pick #(
   parameter  int unsigned N     = 3,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     eligible_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     winner_o,
   output logic             valid_o
);

   always_comb begin : pick
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] j;
      winner_o = '0;
      valid_o  = 1'b0;
      sum      = '0;
      j        = '0;
      for (int unsigned k = 0; k < N; k++) begin
         sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
         end
         j = sum[IDX_W-1:0];
         if (!valid_o && eligible_i[j]) begin
            winner_o[j] = 1'b1;
            valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Request/grant/ack arbiter in front of the single KSZ8851 register I/O engine.
// Optional WAIT watchdog enabled by defining REG_ARB_TIMEOUT_EN.
module reg_bus_arbiter
   import eth_reg_pkg::*;
#(
   parameter int unsigned NREQ = 3
`ifdef REG_ARB_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 1023
`endif
) (
   input  logic                     clk40m,
   input  logic                     reset,
   input  logic                     init_done,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          lock,
   input  logic [NREQ*OFFSET_W-1:0] offset_i,
   input  logic [NREQ-1:0]          length_i,
   input  logic [NREQ-1:0]          wr_i,
   input  logic [NREQ*DATA_W-1:0]   wdata_i,
   output logic [NREQ-1:0]          grant,
   output logic [NREQ-1:0]          ack,
   output logic [DATA_W-1:0]        rdata,
   output logic [OFFSET_W-1:0]      io_offset,
   output logic                     io_length,
   output logic                     io_wr,
   output logic [DATA_W-1:0]        io_wdata,
   output logic                     io_new_cmd,
   input  logic                     io_done,
   input  logic [DATA_W-1:0]        io_rdata,
   output logic                     timeout_err
);

   localparam int unsigned     IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] INIT_MASK = NREQ'(1) << REQ_INIT;

   arb_state_e         state_q;
   logic [NREQ-1:0]    grant_q;
   logic [NREQ-1:0]    ack_q;
   logic [DATA_W-1:0]  rdata_q;
   reg_cmd_t           cmd_q;
   logic               new_cmd_q;
   logic [IDX_W-1:0]   ptr_q;

   logic [NREQ-1:0]    elig;
   logic [NREQ-1:0]    pick_oh;
   logic               pick_valid;
   logic [NREQ-1:0]    sel_oh;
   reg_cmd_t           sel_cmd;
   logic [IDX_W-1:0]   ptr_nxt;
   logic               owner_req;
   logic               owner_lock;
   logic               ack_busy;
   logic               tmo_hit;

   // Requester 0 is served alone before init_done and never after
   assign elig = init_done ? (req & ~INIT_MASK) : (req & INIT_MASK);

   rr_pick #(.N(NREQ)) u_pick (
      .eligible_i (elig),
      .ptr_i      (ptr_q),
      .winner_o   (pick_oh),
      .valid_o    (pick_valid)
   );

   assign owner_req  = |(req & grant_q);
   assign owner_lock = |(lock & grant_q);
   // Requesters drop req one cycle after ack; skip that cycle to avoid a duplicate issue
   assign ack_busy   = |ack_q;
   assign sel_oh     = (state_q == ST_HOLD) ? grant_q : pick_oh;

   always_comb begin
      sel_cmd = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (sel_oh[i]) begin
            sel_cmd.offset = offset_i[i*OFFSET_W +: OFFSET_W];
            sel_cmd.length = length_i[i];
            sel_cmd.wr     = wr_i[i];
            sel_cmd.wdata  = wdata_i[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      ptr_nxt = ptr_q;
      for (int unsigned i = 1; i < NREQ; i++) begin
         if (grant_q[i]) begin
            ptr_nxt = IDX_W'(rr_after(i, NREQ));
         end
      end
   end

`ifdef REG_ARB_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             tmo_err_q;

   assign tmo_hit     = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = tmo_err_q;

   // Watchdog counts WAIT cycles without io_done; error flag is sticky until reset
   always_ff @(posedge clk40m) begin
      if (reset) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else if (state_q != ST_WAIT || io_done) begin
         tmo_cnt_q <= '0;
      end else if (tmo_hit) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b1;
      end else begin
         tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk40m) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         ack_q     <= '0;
         rdata_q   <= '0;
         cmd_q     <= '0;
         new_cmd_q <= 1'b0;
         ptr_q     <= IDX_W'(REQ_TX);
      end else begin
         ack_q     <= '0;
         new_cmd_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!ack_busy && pick_valid) begin
                  cmd_q     <= sel_cmd;
                  grant_q   <= pick_oh;
                  new_cmd_q <= 1'b1;
                  state_q   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (io_done) begin
                  rdata_q <= io_rdata;
                  ack_q   <= grant_q;
                  ptr_q   <= ptr_nxt;
                  if (owner_lock) begin
                     state_q <= ST_HOLD;
                  end else begin
                     grant_q <= '0;
                     state_q <= ST_IDLE;
                  end
               end else if (tmo_hit) begin
                  // Abort: fake completion with the timeout pattern, lock ignored
                  rdata_q <= RDATA_TIMEOUT;
                  ack_q   <= grant_q;
                  ptr_q   <= ptr_nxt;
                  grant_q <= '0;
                  state_q <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (!ack_busy) begin
                  if (owner_req) begin
                     cmd_q     <= sel_cmd;
                     new_cmd_q <= 1'b1;
                     state_q   <= ST_ISSUE;
                  end else if (!owner_lock) begin
                     grant_q <= '0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               grant_q <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant      = grant_q;
   assign ack        = ack_q;
   assign rdata      = rdata_q;
   assign io_offset  = cmd_q.offset;
   assign io_length  = cmd_q.length;
   assign io_wr      = cmd_q.wr;
   assign io_wdata   = cmd_q.wdata;
   assign io_new_cmd = new_cmd_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed self-checking bench for reg_bus_arbiter (NREQ = 3).
module tb_reg_bus_arbiter;

   logic        clk40m = 1'b0;
   logic        reset;
   logic        init_done;
   logic [2:0]  req;
   logic [2:0]  lock;
   logic [23:0] offset_i;
   logic [2:0]  length_i;
   logic [2:0]  wr_i;
   logic [47:0] wdata_i;
   logic [2:0]  grant;
   logic [2:0]  ack;
   logic [15:0] rdata;
   logic [7:0]  io_offset;
   logic        io_length;
   logic        io_wr;
   logic [15:0] io_wdata;
   logic        io_new_cmd;
   logic        io_done;
   logic [15:0] io_rdata;
   logic        timeout_err;

   int n_vec = 0;
   int n_err = 0;

`ifdef REG_ARB_TIMEOUT_EN
   reg_bus_arbiter #(.NREQ(3), .TIMEOUT_CYCLES(16)) dut (
`else
   reg_bus_arbiter #(.NREQ(3)) dut (
`endif
      .clk40m      (clk40m),
      .reset       (reset),
      .init_done   (init_done),
      .req         (req),
      .lock        (lock),
      .offset_i    (offset_i),
      .length_i    (length_i),
      .wr_i        (wr_i),
      .wdata_i     (wdata_i),
      .grant       (grant),
      .ack         (ack),
      .rdata       (rdata),
      .io_offset   (io_offset),
      .io_length   (io_length),
      .io_wr       (io_wr),
      .io_wdata    (io_wdata),
      .io_new_cmd  (io_new_cmd),
      .io_done     (io_done),
      .io_rdata    (io_rdata),
      .timeout_err (timeout_err)
   );

   always #5 clk40m = ~clk40m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits for the command strobe, then completes it dly cycles later; returns in the ack cycle
   task automatic xfer(input string tag, input logic [2:0] exp_g, input logic [7:0] exp_off,
                       input int dly, input logic [15:0] rd);
      int n;
      n = 0;
      while (io_new_cmd !== 1'b1 && n < 20) begin
         @(negedge clk40m);
         n++;
      end
      check({tag, ".cmd"},   32'(io_new_cmd), 32'd1);
      check({tag, ".grant"}, 32'(grant),      32'(exp_g));
      check({tag, ".off"},   32'(io_offset),  32'(exp_off));
      repeat (dly) @(negedge clk40m);
      io_done  = 1'b1;
      io_rdata = rd;
      @(negedge clk40m);
      io_done  = 1'b0;
      check({tag, ".ack"},   32'(ack),   32'(exp_g));
      check({tag, ".rdata"}, 32'(rdata), 32'(rd));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      reset     = 1'b1;
      init_done = 1'b0;
      req       = '0;
      lock      = '0;
      offset_i  = '0;
      length_i  = '0;
      wr_i      = '0;
      wdata_i   = '0;
      io_done   = 1'b0;
      io_rdata  = '0;

      // Reset state
      repeat (3) @(negedge clk40m);
      check("rst.grant", 32'(grant),       32'd0);
      check("rst.ack",   32'(ack),         32'd0);
      check("rst.rdata", 32'(rdata),       32'd0);
      check("rst.off",   32'(io_offset),   32'd0);
      check("rst.cmd",   32'(io_new_cmd),  32'd0);
      check("rst.tmo",   32'(timeout_err), 32'd0);

      // Init phase: only requester 0 eligible
      reset    = 1'b0;
      req      = 3'b111;
      offset_i = {8'h22, 8'h11, 8'h92};
      wr_i     = 3'b001;
      wdata_i  = {16'h3333, 16'h2222, 16'h0100};
      @(negedge clk40m);
      check("init.grant", 32'(grant),      32'b001);
      check("init.cmd",   32'(io_new_cmd), 32'd1);
      check("init.off",   32'(io_offset),  32'h92);
      check("init.wr",    32'(io_wr),      32'd1);
      check("init.wdata", 32'(io_wdata),   32'h0100);
      @(negedge clk40m);
      check("init.cmd1",  32'(io_new_cmd), 32'd0);
      repeat (4) @(negedge clk40m);
      check("init.noack", 32'(ack),        32'd0);
      check("init.cmd2",  32'(io_new_cmd), 32'd0);
      io_done = 1'b1;
      @(negedge clk40m);
      io_done = 1'b0;
      check("init.ack",   32'(ack),   32'b001);
      check("init.rel",   32'(grant), 32'b000);
      @(negedge clk40m);
      req = 3'b110;
      check("init.ack1",  32'(ack),   32'd0);
      repeat (3) @(negedge clk40m);
      check("init.idle",  32'(grant),     32'd0);
      check("init.keep",  32'(io_offset), 32'h92);

      // Round-robin among requesters 1 and 2 with req held high
      init_done = 1'b1;
      wr_i      = 3'b000;
      for (int k = 0; k < 4; k++) begin
         xfer($sformatf("rr%0d", k), (k % 2 == 1) ? 3'b100 : 3'b010,
              (k % 2 == 1) ? 8'h22 : 8'h11, 3, 16'h1000 + 16'(k));
      end
      req = 3'b000;

      // Read from requester 2
      repeat (2) @(negedge clk40m);
      req = 3'b100;
      xfer("rd", 3'b100, 8'h22, 2, 16'hA5C3);
      req = 3'b000;

      // Locked burst by requester 1 while requester 2 waits
      repeat (2) @(negedge clk40m);
      lock = 3'b010;
      req  = 3'b110;
      for (int k = 0; k < 4; k++) begin
         offset_i[15:8] = 8'h40 + 8'(k);
         xfer($sformatf("lk%0d", k), 3'b010, 8'h40 + 8'(k), 2, 16'h2000 + 16'(k));
         check($sformatf("lk%0d.hold", k), 32'(grant), 32'b010);
      end
      lock = 3'b000;
      req  = 3'b100;
      offset_i[15:8] = 8'h11;
      xfer("lkrel", 3'b100, 8'h22, 2, 16'h3000);
      req = 3'b000;

      // Reset in WAIT: pointer returns to 1 and the late io_done is ignored
      repeat (2) @(negedge clk40m);
      req = 3'b010;
      xfer("pre", 3'b010, 8'h11, 2, 16'h4000);
      req = 3'b000;
      repeat (2) @(negedge clk40m);
      req = 3'b010;
      n = 0;
      while (io_new_cmd !== 1'b1 && n < 20) begin
         @(negedge clk40m);
         n++;
      end
      check("rw.cmd", 32'(io_new_cmd), 32'd1);
      @(negedge clk40m);
      reset = 1'b1;
      req   = 3'b000;
      @(negedge clk40m);
      reset    = 1'b0;
      io_done  = 1'b1;
      io_rdata = 16'hBEEF;
      @(negedge clk40m);
      io_done = 1'b0;
      check("rw.ack",   32'(ack),        32'd0);
      check("rw.grant", 32'(grant),      32'd0);
      check("rw.rdata", 32'(rdata),      32'd0);
      check("rw.off",   32'(io_offset),  32'd0);
      check("rw.wdata", 32'(io_wdata),   32'd0);
      check("rw.cmd0",  32'(io_new_cmd), 32'd0);
      req = 3'b110;
      xfer("rw.ptr", 3'b010, 8'h11, 2, 16'h5000);
      req = 3'b000;

`ifdef REG_ARB_TIMEOUT_EN
      // Watchdog: io_done never arrives
      repeat (2) @(negedge clk40m);
      lock = 3'b100;
      req  = 3'b100;
      n = 0;
      while (ack !== 3'b100 && n < 40) begin
         @(negedge clk40m);
         n++;
      end
      req  = 3'b000;
      lock = 3'b000;
      check("tmo.ack",   32'(ack),         32'b100);
      check("tmo.rdata", 32'(rdata),       32'hFFFF);
      check("tmo.err",   32'(timeout_err), 32'd1);
      check("tmo.rel",   32'(grant),       32'd0);
      repeat (5) @(negedge clk40m);
      check("tmo.sticky", 32'(timeout_err), 32'd1);
      reset = 1'b1;
      @(negedge clk40m);
      reset = 1'b0;
      check("tmo.clr", 32'(timeout_err), 32'd0);
`else
      check("tmo.tied", 32'(timeout_err), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
